wb_src_select: RTL

Parametrised successor to the register-file write-data source mux. Selects one of NUM_SRC datapath sources (load/store unit, HI, LO, shifter, constants, sign-extend, ALUOut, and others) for register writeback.
- Adds a request/valid handshake so multi-cycle sources (HI/LO during MULT/DIV, load data) can stall the writeback until the data is ready.
- Registers the selected data and destination, and flags illegal selects.
- Sits between the datapath sources and the register-file write port; driven by the control unit.

---
 rtl/wb_src_select.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/wb_src_select.sv
// Writeback source select: picks one of NUM_SRC sources, waits for slow sources, registers result.
// Latency 1 cycle from req (ready source) or from src_valid rising (WAIT); busy=1 blocks new req.
// Optional WB_TIMEOUT_EN: aborts WAIT after TIMEOUT cycles with an err_timeout pulse.
module wb_src_select #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 8,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*WIDTH-1:0] src_bus,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic                     req,
    input  logic [SEL_W-1:0]         sel,
    input  logic [4:0]               dest_in,
    input  logic                     we_in,
    input  logic                     flush,
    output logic                     busy,
    output logic                     wb_valid,
    output logic [WIDTH-1:0]         wb_data,
    output logic [4:0]               wb_reg,
    output logic                     wb_we,
    output logic                     err_bad_sel,
    output logic                     err_timeout
);

    localparam int NPAD = 1 << SEL_W;

    if (NUM_SRC < 2 || NUM_SRC > 16 || NPAD < NUM_SRC || TIMEOUT < 2) begin : g_bad_param
        $error("wb_src_select: illegal parameter combination");
    end

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    // Sources padded to the full sel range so any sel value indexes safely.
    logic [WIDTH-1:0] src_arr [NPAD];
    logic [NPAD-1:0]  vld_pad;

    for (genvar g = 0; g < NPAD; g++) begin : g_pad
        if (g < NUM_SRC) begin : g_src
            assign src_arr[g] = src_bus[g*WIDTH +: WIDTH];
            assign vld_pad[g] = src_valid[g];
        end else begin : g_zero
            assign src_arr[g] = '0;
            assign vld_pad[g] = 1'b0;
        end
    end

    state_t           state;
    logic [SEL_W-1:0] sel_q;
    logic [4:0]       dest_q;
    logic             we_pend;
    logic             we_q;
    logic             sel_ok;

    assign sel_ok = ({1'b0, sel} < (SEL_W+1)'(NUM_SRC));
    assign busy   = (state == S_WAIT);
    assign wb_we  = wb_valid & we_q;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] cnt;
    logic             err_to_q;
    assign err_timeout = err_to_q;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            sel_q       <= '0;
            dest_q      <= '0;
            we_pend     <= 1'b0;
            we_q        <= 1'b0;
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_reg      <= '0;
            err_bad_sel <= 1'b0;
`ifdef WB_TIMEOUT_EN
            cnt         <= '0;
            err_to_q    <= 1'b0;
`endif
        end else begin
            wb_valid    <= 1'b0;
            err_bad_sel <= 1'b0;
`ifdef WB_TIMEOUT_EN
            err_to_q    <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    // flush in IDLE swallows a coincident req, including a bad one.
                    if (req && !flush) begin
                        if (!sel_ok) begin
                            err_bad_sel <= 1'b1;
                        end else if (vld_pad[sel]) begin
                            wb_data  <= src_arr[sel];
                            wb_reg   <= dest_in;
                            we_q     <= we_in;
                            wb_valid <= 1'b1;
                        end else begin
                            sel_q   <= sel;
                            dest_q  <= dest_in;
                            we_pend <= we_in;
                            state   <= S_WAIT;
`ifdef WB_TIMEOUT_EN
                            cnt     <= '0;
`endif
                        end
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (vld_pad[sel_q]) begin
                        wb_data  <= src_arr[sel_q];
                        wb_reg   <= dest_q;
                        we_q     <= we_pend;
                        wb_valid <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
`ifdef WB_TIMEOUT_EN
                        if (cnt == CNT_W'(TIMEOUT - 1)) begin
                            err_to_q <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
